// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared types and sizing helpers for the mem_ctl bus initiator.
// Holds the bus FSM state encoding and default bus widths.
package mem_bus_pkg;

    localparam int DEF_ADDR_W = 7;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/mem_bus_timer.sv
// mem_bus_timer: loadable down-counter timing each bus phase.
// done is high while the count reads zero; the count parks at zero.
module mem_bus_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count;

    // Load on phase entry, otherwise count down to zero and stop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/mem_bus_master.sv
// mem_bus_master: generates setup/strobe/hold read and write cycles for mem_ctl.
// Optional MEM_BUS_MASTER_WAIT_EN adds wait_n to stretch the strobe phase.
module mem_bus_master
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 4,
    parameter int HOLD_CYC   = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
`ifdef MEM_BUS_MASTER_WAIT_EN
    input  logic              wait_n,
`endif
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              ce_n,
    output logic              read_n,
    output logic              write_n,
    output logic [ADDR_W-1:0] address_bus,
    inout  wire  [DATA_W-1:0] data_bus
);

    localparam int CNT_W =
        $clog2(max3(SETUP_CYC, STROBE_CYC, HOLD_CYC)) + 1;

    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);

    state_t            state;
    logic              write_q;
    logic [DATA_W-1:0] wdata_q;
    logic              drive;
    logic              accept;
    logic              done;
    logic              strobe_go;
    logic              strobe_end;
    logic              load;
    logic [CNT_W-1:0]  load_val;

`ifdef MEM_BUS_MASTER_WAIT_EN
    assign strobe_go = wait_n;
`else
    assign strobe_go = 1'b1;
`endif

    assign req_ready  = (state == IDLE);
    assign accept     = req_valid && req_ready;
    assign strobe_end = done && strobe_go;

    // Write data is only ever driven from SETUP through HOLD of a write.
    assign data_bus = drive ? wdata_q : {DATA_W{1'bz}};

    mem_bus_timer #(
        .W(CNT_W)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load),
        .load_val(load_val),
        .done    (done)
    );

    // Reload the phase timer with the next phase length on every transition.
    always_comb begin
        load     = 1'b0;
        load_val = SETUP_LD;
        unique case (state)
            IDLE: begin
                load     = accept;
                load_val = SETUP_LD;
            end
            SETUP: begin
                load     = done;
                load_val = STROBE_LD;
            end
            STROBE: begin
                load     = strobe_end;
                load_val = HOLD_LD;
            end
            HOLD: begin
                load     = 1'b0;
                load_val = SETUP_LD;
            end
            default: begin
                load     = 1'b0;
                load_val = SETUP_LD;
            end
        endcase
    end

    // Bus FSM; every strobe and bus output comes straight from a flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            write_q     <= 1'b0;
            wdata_q     <= '0;
            drive       <= 1'b0;
            address_bus <= '0;
            ce_n        <= 1'b1;
            read_n      <= 1'b1;
            write_n     <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        state       <= SETUP;
                        write_q     <= req_write;
                        wdata_q     <= req_wdata;
                        address_bus <= req_addr;
                        drive       <= req_write;
                    end
                end
                SETUP: begin
                    if (done) begin
                        state   <= STROBE;
                        ce_n    <= 1'b0;
                        read_n  <= write_q;
                        write_n <= !write_q;
                    end
                end
                STROBE: begin
                    if (strobe_end) begin
                        state   <= HOLD;
                        ce_n    <= 1'b1;
                        read_n  <= 1'b1;
                        write_n <= 1'b1;
                        if (!write_q) begin
                            rsp_rdata <= data_bus;
                        end
                    end
                end
                HOLD: begin
                    if (done) begin
                        state     <= IDLE;
                        drive     <= 1'b0;
                        rsp_valid <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_master.sv
// tb_mem_bus_master: directed checks of mem_bus_master bus timing and handshake.
// A small memory model drives data_bus while read_n is low.
module tb_mem_bus_master;

    logic       clk;
    logic       reset_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [6:0] req_addr;
    logic [7:0] req_wdata;
    logic       wait_n;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       ce_n;
    logic       read_n;
    logic       write_n;
    logic [6:0] address_bus;
    wire  [7:0] data_bus;

    logic       tb_en;
    logic [7:0] tb_val;
    logic [7:0] mem_val;

    int n_cmp;
    int n_bad;

    // Memory answers reads; otherwise an optional probe value exposes a DUT driver.
    assign data_bus = !read_n ? mem_val : (tb_en ? tb_val : 8'bz);

    mem_bus_master dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
`ifdef MEM_BUS_MASTER_WAIT_EN
        .wait_n     (wait_n),
`endif
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .ce_n       (ce_n),
        .read_n     (read_n),
        .write_n    (write_n),
        .address_bus(address_bus),
        .data_bus   (data_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after the accept edge; checks cycles 1..S+T+w+H+1.
    task automatic check_txn(input logic wr, input logic [6:0] a,
                             input logic [7:0] d, input logic [7:0] rd_exp,
                             input int w);
        int  n;
        bit  strb;
        bit  busy;
        n      = 7 + w;
        tb_en  = !wr;
        tb_val = 8'h5A;
        for (int k = 1; k <= n; k++) begin
            wait_n = !(k >= 5 && k < 5 + w);
            @(negedge clk);
            strb = (k >= 2 && k <= 5 + w);
            busy = (k <= 6 + w);
            chk("ce_n", ce_n, !strb);
            chk("write_n", write_n, !(strb && wr));
            chk("read_n", read_n, !(strb && !wr));
            chk("rsp_valid", rsp_valid, k == n);
            chk("req_ready", req_ready, k == n);
            if (busy) chk("addr", address_bus, a);
            if (wr && busy) chk("data_wr", data_bus, d);
            if (!wr) chk("data_rd", data_bus, strb ? mem_val : 8'h5A);
            if (k == n) chk("rdata", rsp_rdata, rd_exp);
            if (k < n) begin
                @(posedge clk);
                #1;
            end
        end
        tb_en  = 1'b0;
        wait_n = 1'b1;
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        wait_n    = 1'b1;
        tb_en     = 1'b1;
        tb_val    = 8'h5A;
        mem_val   = 8'h00;

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_ce_n", ce_n, 1'b1);
        chk("rst_read_n", read_n, 1'b1);
        chk("rst_write_n", write_n, 1'b1);
        chk("rst_data_z", data_bus, 8'h5A);
        chk("rst_ready", req_ready, 1'b1);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_addr", address_bus, 7'h00);
        chk("rst_rdata", rsp_rdata, 8'h00);
        tb_en = 1'b0;

        // Write 0x73 to 0x05
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 7'h05;
        req_wdata = 8'h73;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check_txn(1'b1, 7'h05, 8'h73, 8'h00, 0);

        // Read 0x05, memory returns 0x73
        mem_val   = 8'h73;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 7'h05;
        req_wdata = 8'hEE;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check_txn(1'b0, 7'h05, 8'hEE, 8'h73, 0);

        // Back-to-back: write 0x11 to 0x01, then read 0x01 held valid
        @(negedge clk);
        mem_val   = 8'h11;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 7'h01;
        req_wdata = 8'h11;
        @(posedge clk);
        #1;
        req_write = 1'b0;
        req_wdata = 8'hEE;
        check_txn(1'b1, 7'h01, 8'h11, 8'h73, 0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check_txn(1'b0, 7'h01, 8'hEE, 8'h11, 0);

        // Reset mid-strobe of a write
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 7'h09;
        req_wdata = 8'h42;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("pre_rst_ce_n", ce_n, 1'b0);
        chk("pre_rst_data", data_bus, 8'h42);
        tb_en   = 1'b1;
        tb_val  = 8'h5A;
        reset_n = 1'b0;
        #1;
        chk("abort_ce_n", ce_n, 1'b1);
        chk("abort_write_n", write_n, 1'b1);
        chk("abort_read_n", read_n, 1'b1);
        chk("abort_addr", address_bus, 7'h00);
        chk("abort_data_z", data_bus, 8'h5A);
        chk("abort_rdata", rsp_rdata, 8'h00);
        chk("abort_ready", req_ready, 1'b1);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("abort_no_rsp", rsp_valid, 1'b0);
            chk("abort_idle_ce_n", ce_n, 1'b1);
        end
        tb_en = 1'b0;

        // Recovery: write to the top address
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 7'h7F;
        req_wdata = 8'h3C;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check_txn(1'b1, 7'h7F, 8'h3C, 8'h00, 0);

`ifdef MEM_BUS_MASTER_WAIT_EN
        // Read with three wait cycles
        @(negedge clk);
        mem_val   = 8'h73;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 7'h05;
        req_wdata = 8'hEE;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check_txn(1'b0, 7'h05, 8'hEE, 8'h73, 3);
`endif

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_bus_master.md
# mem_bus_master

Synchronous bus initiator that generates microcontroller-style read and write cycles toward the CPLD memory controller `mem_ctl`. It drives `ce_n`, `read_n`, `write_n`, the 7-bit address bus, and the bidirectional 8-bit data bus. It accepts one request at a time from a local valid/ready port and returns a one-cycle response carrying read data. It lets the team exercise `mem_ctl` and the SRAM path from synthesizable logic instead of hand-timed stimulus.

## Interface
- `ADDR_W`, 7, address bus width.
- `DATA_W`, 8, data bus width.
- `SETUP_CYC`, 1, cycles with the address and write data valid before the strobe; must be ≥1.
- `STROBE_CYC`, 4, cycles with `ce_n` and the strobe asserted; must be ≥1.
- `HOLD_CYC`, 1, cycles with the address and write data held after the strobe; must be ≥1.

Ports:
- `clk`  in  1  system clock; all logic runs on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block is idle and will accept a request.
- `req_write`  in  1  1 = write cycle, 0 = read cycle.
- `req_addr`  in  ADDR_W  target address.
- `req_wdata`  in  DATA_W  write data.
- `rsp_valid`  out  1  one-cycle completion pulse, issued for both reads and writes.
- `rsp_rdata`  out  DATA_W  captured read data; holds its value until the next read completes.
- `ce_n`, `read_n`, `write_n`  out  1  active-low bus strobes, all driven from flops.
- `address_bus`  out  ADDR_W  bus address.
- `data_bus`  inout  DATA_W  driven only during write cycles; high-Z otherwise.

## Operation
- The FSM has four states: IDLE, SETUP, STROBE, HOLD.
- A request is accepted on the edge where `req_valid && req_ready`. On that edge the block latches `req_write`, `req_addr` and `req_wdata`, then moves IDLE→SETUP.
- SETUP:
  - `address_bus` = latched address.
  - On a write, `data_bus` is driven with the latched data.
  - All strobes stay high.
  - Lasts SETUP_CYC cycles.
- STROBE:
  - `ce_n` = 0.
  - `write_n` = 0 on a write; `read_n` = 0 on a read.
  - Lasts STROBE_CYC cycles.
  - On a read, `data_bus` is sampled into `rsp_rdata` on the edge that ends the last STROBE cycle.
- HOLD:
  - All strobes are high.
  - Address, and write data on a write, stay driven.
  - Lasts HOLD_CYC cycles, then the FSM returns to IDLE.
- On entry to IDLE from HOLD, `rsp_valid` = 1 for exactly one cycle.
- `req_ready` = (state == IDLE), combinational from the state register.
- A new request accepted in the same cycle as `rsp_valid` is legal (back-to-back operation).
- Bus ownership:
  - `data_bus` is never driven while `read_n` = 0.
  - After a read, the first cycle in which `data_bus` is driven is at least one cycle after `read_n` rises (SETUP of the next write).
- Cycle counter:
  - One down-counter, width = $clog2(max(SETUP_CYC, STROBE_CYC, HOLD_CYC)) + 1.
  - Loaded with (phase length − 1) on each phase entry.
  - The phase ends when the counter reads 0.
- Reset (asynchronous, any state, including mid-strobe):
  - State goes to IDLE.
  - `ce_n`, `read_n`, `write_n` = 1; `address_bus` = 0; `data_bus` = Z.
  - `rsp_valid` = 0; `rsp_rdata` = 0; `req_ready` = 1 after reset deasserts.
  - An aborted cycle produces no response.
- While not in IDLE, `req_valid` is ignored and request inputs may change freely.

## Timing
- Let E0 be the accept edge and S/T/H = SETUP_CYC/STROBE_CYC/HOLD_CYC. Phases run:
  - Cycles 1..S: SETUP.
  - Cycles S+1..S+T: STROBE.
  - Cycles S+T+1..S+T+H: HOLD.
  - Cycle S+T+H+1: IDLE with `rsp_valid` = 1.
- With defaults the strobe is low in cycles 2–5, `rsp_valid` is high in cycle 7, and read data is sampled at edge E5.
- Per-transaction occupancy is S+T+H+1 cycles. Sustained throughput is one transaction per S+T+H+1 cycles.
- `address_bus` is stable from cycle 1 through cycle S+T+H.
- `ce_n` and the active strobe change on the same edge; no glitches, since both are flop outputs.

## Configuration
- Macro: `MEM_BUS_MASTER_WAIT_EN`.
- Defined:
  - Adds input `wait_n` (1 bit, active-low).
  - If `wait_n` = 0 when the STROBE counter is 0, STROBE extends one cycle, and this repeats each cycle while `wait_n` stays low.
  - Read-data sampling moves to the edge that actually ends STROBE.
- Undefined: the port does not exist and STROBE is exactly STROBE_CYC cycles.

## Structure
- Package `mem_bus_pkg` holds:
  - The state enum (IDLE/SETUP/STROBE/HOLD).
  - Default `ADDR_W`/`DATA_W` constants.
  - A `max3` helper function for sizing the counter.
- One sub-module, `mem_bus_timer`: a loadable down-counter with a `done` output (counter == 0). The FSM and bus drivers stay in `mem_bus_master`.

## Test plan
- Reset, then idle 5 cycles → `ce_n` = `read_n` = `write_n` = 1, `data_bus` = Z, `req_ready` = 1, `rsp_valid` = 0.
- Write 0x73 to address 0x05 with defaults:
  - `address_bus` = 0x05 and `data_bus` = 0x73 in cycles 1–6.
  - `ce_n` = `write_n` = 0 in cycles 2–5.
  - `rsp_valid` pulse in cycle 7.
- Read address 0x05 with the bench model driving 0x73 while `read_n` = 0 → `data_bus` is never driven by the DUT, `rsp_rdata` = 0x73 with `rsp_valid` in cycle 7.
- Back-to-back: write 0x11 to 0x01, then read 0x01 with the request held valid → the second accept occurs in the `rsp_valid` cycle and the strobes never overlap.
- Assert `reset_n` = 0 during cycle 3 of a write → the strobes rise and the bus goes Z immediately; no `rsp_valid` after release.
- With `MEM_BUS_MASTER_WAIT_EN`, hold `wait_n` = 0 for 3 extra cycles on a read → strobe low in cycles 2–8, data sampled at E8, `rsp_valid` in cycle 10.
